memory_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, sitting between execute and writeback. Accepts the M-stage instruction, runs load/store traffic against the data memory over a req/ready handshake with byte enables and load extension, stalls upstream while an access is outstanding, and registers the MEM/WB bundle (ReadDataW, ALUOutW, MemtoRegW, RegWriteW, WriteRegW) that the writeback stage consumes.

---
 rtl/memory_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage
// Purpose  : Memory-access stage of the five-stage RISC-V pipeline. Issues
//            load/store traffic to data memory over a req/ready handshake,
//            with byte enables, lane-replicated store data and load
//            sign/zero extension. Stalls upstream while an access is
//            outstanding and registers the MEM/WB bundle for writeback.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   ValidM            : M-stage instruction valid
//   MemReadM/MemWriteM: load / store (both high is a store)
//   MemtoRegM/RegWriteM, WriteRegM : writeback controls and destination
//   Funct3M           : access size / signedness
//   ALUOutM           : effective address or ALU result
//   WriteDataM        : store data
//   dmem_*            : data-memory request/response handshake
//   StallM            : hold IF/ID/EX and the M-stage inputs
//   *W                : registered MEM/WB bundle
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, misaligned H/W accesses are not
//                        issued; they pass to W with MisalignW=1.
// ============================================================================
module memory_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        ValidM,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic        RegWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  WriteRegM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic        MemtoRegW,
   output logic        RegWriteW,
   output logic        ValidW,
   output logic [4:0]  WriteRegW,
   output logic        MisalignW
);

   typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t      state_q, state_d;

   // Request registers: everything the access needs, frozen for all of REQ.
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] req_wdata_q, req_wdata_d;
   logic [3:0]  req_be_q, req_be_d;
   logic        req_we_q, req_we_d;
   logic [2:0]  req_funct3_q, req_funct3_d;
   logic [4:0]  req_wreg_q, req_wreg_d;
   logic        req_memtoreg_q, req_memtoreg_d;
   logic        req_regwrite_q, req_regwrite_d;

   // MEM/WB registers
   logic [31:0] rdata_w_q, rdata_w_d;
   logic [31:0] alu_w_q, alu_w_d;
   logic        memtoreg_w_q, memtoreg_w_d;
   logic        regwrite_w_q, regwrite_w_d;
   logic        valid_w_q, valid_w_d;
   logic [4:0]  wreg_w_q, wreg_w_d;
   logic        misalign_w_q, misalign_w_d;

   logic        misalign;
   logic        mem_op;
   logic [31:0] st_wdata;
   logic [3:0]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

`ifdef MEM_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if (ValidM && (MemReadM || MemWriteM)) begin
         case (Funct3M[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUOutM[0];
            default: misalign = (ALUOutM[1:0] != 2'b00);
         endcase
      end
   end
`else
   assign misalign = 1'b0;
`endif

   assign mem_op = ValidM & (MemReadM | MemWriteM) & ~misalign;

   // Store formatting: size comes from Funct3M[1:0]; 1x encodings are words.
   always_comb begin
      st_wdata = WriteDataM;
      st_be    = 4'b1111;
      case (Funct3M[1:0])
         2'b00: begin
            st_wdata = {4{WriteDataM[7:0]}};
            st_be    = 4'b0001 << ALUOutM[1:0];
         end
         2'b01: begin
            st_wdata = {2{WriteDataM[15:0]}};
            st_be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = WriteDataM;
            st_be    = 4'b1111;
         end
      endcase
   end

   // Load lane select and extension from the latched address/size.
   always_comb begin
      case (req_addr_q[1:0])
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = req_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (req_funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h000000, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0000, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      req_addr_d     = req_addr_q;
      req_wdata_d    = req_wdata_q;
      req_be_d       = req_be_q;
      req_we_d       = req_we_q;
      req_funct3_d   = req_funct3_q;
      req_wreg_d     = req_wreg_q;
      req_memtoreg_d = req_memtoreg_q;
      req_regwrite_d = req_regwrite_q;
      // W registers default to a bubble every cycle.
      rdata_w_d      = 32'h0;
      alu_w_d        = 32'h0;
      memtoreg_w_d   = 1'b0;
      regwrite_w_d   = 1'b0;
      valid_w_d      = 1'b0;
      wreg_w_d       = 5'h0;
      misalign_w_d   = 1'b0;
      StallM         = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               req_addr_d     = ALUOutM;
               req_wdata_d    = st_wdata;
               req_be_d       = st_be;
               req_we_d       = MemWriteM;
               req_funct3_d   = Funct3M;
               req_wreg_d     = WriteRegM;
               req_memtoreg_d = MemtoRegM;
               req_regwrite_d = RegWriteM;
               StallM         = 1'b1;
               state_d        = REQ;
            end else if (ValidM) begin
               // Plain ALU op, or a misaligned access that is not issued.
               alu_w_d      = ALUOutM;
               memtoreg_w_d = MemtoRegM;
               regwrite_w_d = RegWriteM & ~misalign;
               valid_w_d    = 1'b1;
               wreg_w_d     = WriteRegM;
               misalign_w_d = misalign;
            end
         end
         REQ: begin
            if (dmem_ready) begin
               alu_w_d      = req_addr_q;
               rdata_w_d    = req_we_q ? 32'h0 : ld_data;
               memtoreg_w_d = req_memtoreg_q;
               regwrite_w_d = req_regwrite_q & ~req_we_q;
               valid_w_d    = 1'b1;
               wreg_w_d     = req_wreg_q;
               state_d      = IDLE;
            end else begin
               StallM = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         req_addr_q     <= 32'h0;
         req_wdata_q    <= 32'h0;
         req_be_q       <= 4'h0;
         req_we_q       <= 1'b0;
         req_funct3_q   <= 3'h0;
         req_wreg_q     <= 5'h0;
         req_memtoreg_q <= 1'b0;
         req_regwrite_q <= 1'b0;
         rdata_w_q      <= 32'h0;
         alu_w_q        <= 32'h0;
         memtoreg_w_q   <= 1'b0;
         regwrite_w_q   <= 1'b0;
         valid_w_q      <= 1'b0;
         wreg_w_q       <= 5'h0;
         misalign_w_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_addr_q     <= req_addr_d;
         req_wdata_q    <= req_wdata_d;
         req_be_q       <= req_be_d;
         req_we_q       <= req_we_d;
         req_funct3_q   <= req_funct3_d;
         req_wreg_q     <= req_wreg_d;
         req_memtoreg_q <= req_memtoreg_d;
         req_regwrite_q <= req_regwrite_d;
         rdata_w_q      <= rdata_w_d;
         alu_w_q        <= alu_w_d;
         memtoreg_w_q   <= memtoreg_w_d;
         regwrite_w_q   <= regwrite_w_d;
         valid_w_q      <= valid_w_d;
         wreg_w_q       <= wreg_w_d;
         misalign_w_q   <= misalign_w_d;
      end
   end

   // Request side is sourced only from state and request registers, so it
   // is glitch-free and drops as soon as reset clears the state.
   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = dmem_req & req_we_q;
   assign dmem_be    = dmem_req ? req_be_q : 4'h0;
   assign dmem_addr  = {req_addr_q[31:2], 2'b00};
   assign dmem_wdata = req_wdata_q;

   assign ReadDataW  = rdata_w_q;
   assign ALUOutW    = alu_w_q;
   assign MemtoRegW  = memtoreg_w_q;
   assign RegWriteW  = regwrite_w_q;
   assign ValidW     = valid_w_q;
   assign WriteRegW  = wreg_w_q;
   assign MisalignW  = misalign_w_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Self-checking bench for memory_stage. Expected MEM/WB bundles
//            are queued as each instruction is driven and compared whenever
//            the stage presents ValidW. Request-side outputs and StallM are
//            checked inline by the driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

   logic        clk;
   logic        rst;
   logic        ValidM, MemReadM, MemWriteM, MemtoRegM, RegWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUOutM, WriteDataM;
   logic [4:0]  WriteRegM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        StallM;
   logic [31:0] ReadDataW, ALUOutW;
   logic        MemtoRegW, RegWriteW, ValidW;
   logic [4:0]  WriteRegW;
   logic        MisalignW;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] rdata;
      logic        m2r;
      logic        rw;
      logic [4:0]  wreg;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef MEM_ALIGN_CHECK_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif

   memory_stage dut (
      .clk        (clk),
      .rst        (rst),
      .ValidM     (ValidM),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .MemtoRegM  (MemtoRegM),
      .RegWriteM  (RegWriteM),
      .Funct3M    (Funct3M),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .WriteRegM  (WriteRegM),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .StallM     (StallM),
      .ReadDataW  (ReadDataW),
      .ALUOutW    (ALUOutW),
      .MemtoRegW  (MemtoRegW),
      .RegWriteW  (RegWriteW),
      .ValidW     (ValidW),
      .WriteRegW  (WriteRegW),
      .MisalignW  (MisalignW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every valid W bundle must match the oldest entry.
   always @(negedge clk) begin
      if (rst && ValidW) begin
         check_val("sb_pop", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_val("w_aluout",   ALUOutW,   mon_e.alu);
            check_val("w_readdata", ReadDataW, mon_e.rdata);
            check_val("w_memtoreg", 32'(MemtoRegW), 32'(mon_e.m2r));
            check_val("w_regwrite", 32'(RegWriteW), 32'(mon_e.rw));
            check_val("w_writereg", 32'(WriteRegW), 32'(mon_e.wreg));
            check_val("w_misalign", 32'(MisalignW), 32'(mon_e.mis));
         end
      end
   end

   // Drive one M-stage instruction and play the memory side.
   task automatic run_op(input string nm, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] wreg,
                         input logic m2r, input logic rw,
                         input logic [31:0] rdata, input int wait_cyc,
                         input logic mis, input logic [31:0] exp_ld,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      exp_t e;
      int   stalls;
      @(negedge clk);
      ValidM = 1'b1; MemReadM = rd; MemWriteM = wr; MemtoRegM = m2r;
      RegWriteM = rw; Funct3M = f3; ALUOutM = addr; WriteDataM = wd;
      WriteRegM = wreg; dmem_rdata = 32'h0;
      e.alu = addr; e.m2r = m2r; e.wreg = wreg;
      if (!(rd || wr) || mis) begin
         // No memory request expected; dmem_ready is held high to show it is ignored.
         dmem_ready = 1'b1;
         e.rdata = 32'h0; e.rw = rw & ~mis; e.mis = mis;
         sb_q.push_back(e);
         #1;
         check_val({nm, "_stall"}, 32'(StallM), 32'd0);
         check_val({nm, "_noreq"}, 32'(dmem_req), 32'd0);
         @(negedge clk);
         ValidM = 1'b0; dmem_ready = 1'b0;
         check_val({nm, "_validw"}, 32'(ValidW), 32'd1);
         check_val({nm, "_noreq2"}, 32'(dmem_req), 32'd0);
      end else begin
         dmem_ready = 1'b0;
         e.rdata = wr ? 32'h0 : exp_ld; e.rw = rw & ~wr; e.mis = 1'b0;
         sb_q.push_back(e);
         stalls = 0;
         #1;
         if (StallM) stalls++;
         check_val({nm, "_req_idle"}, 32'(dmem_req), 32'd0);
         @(negedge clk);
         check_val({nm, "_req"},  32'(dmem_req), 32'd1);
         check_val({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
         check_val({nm, "_we"},   32'(dmem_we), 32'(wr));
         check_val({nm, "_bubble"}, 32'(ValidW), 32'd0);
         if (wr) begin
            check_val({nm, "_be"},    32'(dmem_be), 32'(exp_be));
            check_val({nm, "_wdata"}, dmem_wdata, exp_wdata);
         end
         for (int i = 0; i < wait_cyc; i++) begin
            #1;
            if (StallM) stalls++;
            @(negedge clk);
            check_val({nm, "_req_hold"}, 32'(dmem_req), 32'd1);
            check_val({nm, "_bubble_w"}, 32'(ValidW), 32'd0);
         end
         dmem_ready = 1'b1; dmem_rdata = rdata;
         #1;
         check_val({nm, "_stall_rdy"}, 32'(StallM), 32'd0);
         @(negedge clk);
         ValidM = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
         check_val({nm, "_validw"}, 32'(ValidW), 32'd1);
         check_val({nm, "_stalls"}, 32'(stalls), 32'(wait_cyc + 1));
         check_val({nm, "_req_done"}, 32'(dmem_req), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
      RegWriteM = 1'b0; Funct3M = 3'b000; ALUOutM = 32'h0; WriteDataM = 32'h0;
      WriteRegM = 5'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_req",     32'(dmem_req),  32'd0);
      check_val("rst_stall",   32'(StallM),    32'd0);
      check_val("rst_validw",  32'(ValidW),    32'd0);
      check_val("rst_regw",    32'(RegWriteW), 32'd0);
      check_val("rst_aluout",  ALUOutW,        32'h0);
      check_val("rst_rdata",   ReadDataW,      32'h0);
      check_val("rst_mis",     32'(MisalignW), 32'd0);
      check_val("rst_addr",    dmem_addr,      32'h0);
      check_val("rst_be",      32'(dmem_be),   32'd0);
      @(negedge clk);
      rst = 1'b1;

      //        name    rd  wr  f3      addr          wdata         wreg m2r rw rdata         wait mis      exp_ld        be       wdata
      run_op("add",  0, 0, 3'b000, 32'h00001234, 32'h0,        5'd5, 0, 1, 32'h0,        0, 1'b0,    32'h0,        4'h0,    32'h0);
      run_op("sb",   0, 1, 3'b000, 32'h00000103, 32'h000000A5, 5'd7, 0, 1, 32'h0,        0, 1'b0,    32'h0,        4'b1000, 32'hA5A5A5A5);
      run_op("lb",   1, 0, 3'b000, 32'h00000102, 32'h0,        5'd8, 1, 1, 32'h00800000, 1, 1'b0,    32'hFFFFFF80, 4'h0,    32'h0);
      run_op("lbu",  1, 0, 3'b100, 32'h00000102, 32'h0,        5'd9, 1, 1, 32'h00800000, 0, 1'b0,    32'h00000080, 4'h0,    32'h0);
      run_op("lh",   1, 0, 3'b001, 32'h00000102, 32'h0,        5'd10,1, 1, 32'h80010000, 0, 1'b0,    32'hFFFF8001, 4'h0,    32'h0);
      run_op("lhu",  1, 0, 3'b101, 32'h00000100, 32'h0,        5'd11,1, 1, 32'h1234ABCD, 2, 1'b0,    32'h0000ABCD, 4'h0,    32'h0);
      run_op("sh",   0, 1, 3'b001, 32'h00000102, 32'h0000BEEF, 5'd12,0, 1, 32'h0,        0, 1'b0,    32'h0,        4'b1100, 32'hBEEFBEEF);
      run_op("sw",   1, 1, 3'b010, 32'h00000200, 32'hCAFEF00D, 5'd13,0, 1, 32'h0,        2, 1'b0,    32'h0,        4'b1111, 32'hCAFEF00D);
      run_op("lw",   1, 0, 3'b010, 32'h00000300, 32'h0,        5'd14,1, 1, 32'h89ABCDEF, 3, 1'b0,    32'h89ABCDEF, 4'h0,    32'h0);
      run_op("lwmis",1, 0, 3'b010, 32'h00000101, 32'h0,        5'd15,1, 1, 32'hDEADBEEF, 0, ALIGN_EN, 32'hDEADBEEF, 4'h0,    32'h0);
      run_op("lbmis",1, 0, 3'b000, 32'h00000101, 32'h0,        5'd16,1, 1, 32'h0000C300, 0, 1'b0,    32'hFFFFFFC3, 4'h0,    32'h0);

      // Bubble: ValidM low leaves W invalid.
      @(negedge clk);
      #1;
      check_val("bubble_validw", 32'(ValidW), 32'd0);
      check_val("bubble_regw",   32'(RegWriteW), 32'd0);

      // Reset while a load is outstanding.
      @(negedge clk);
      ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
      ALUOutM = 32'h00000400; RegWriteM = 1'b1; WriteRegM = 5'd20; dmem_ready = 1'b0;
      @(negedge clk);
      check_val("rreq_req", 32'(dmem_req), 32'd1);
      ValidM = 1'b0; MemReadM = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_val("rreq_req_drop", 32'(dmem_req),  32'd0);
      check_val("rreq_stall",    32'(StallM),    32'd0);
      check_val("rreq_validw",   32'(ValidW),    32'd0);
      check_val("rreq_aluout",   ALUOutW,        32'h0);
      check_val("rreq_regw",     32'(RegWriteW), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("rreq_idle", 32'(dmem_req), 32'd0);

      run_op("add2", 0, 0, 3'b000, 32'h0000ABCD, 32'h0, 5'd21, 0, 1, 32'h0, 0, 1'b0, 32'h0, 4'h0, 32'h0);

      repeat (2) @(negedge clk);
      check_val("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
